// File: rtl/ped_signal_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ped_signal_pkg : pedestrian-signal state encoding and timing defaults
// Revision 1.0
// ------------------------------------------------------------------
package ped_signal_pkg;

  typedef logic [1:0] ped_state_t;

  localparam ped_state_t C_ST_IDLE  = 2'd0;
  localparam ped_state_t C_ST_WALK  = 2'd1;
  localparam ped_state_t C_ST_CLEAR = 2'd2;
  localparam ped_state_t C_ST_HOLD  = 2'd3;

  localparam int C_WALK_TIME_DEF  = 7;
  localparam int C_CLEAR_TIME_DEF = 10;
  localparam int C_CNT_W          = 7;

endpackage
`default_nettype wire

// File: rtl/ped_btn_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// ped_btn_sync : 2-flop button synchronizer with rising-edge pulse
// Revision 1.0
// ------------------------------------------------------------------
module ped_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign pulse = r_sync2 & ~r_sync3;

endmodule
`default_nettype wire

// File: rtl/ped_signal.sv
`default_nettype none
// ------------------------------------------------------------------
// ped_signal : pedestrian WALK/DON'T-WALK controller slaved to vehicle lights
// Revision 1.0
// ------------------------------------------------------------------
module ped_signal
  import ped_signal_pkg::*;
#(
  parameter int WALK_TIME  = C_WALK_TIME_DEF,
  parameter int CLEAR_TIME = C_CLEAR_TIME_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       tick,
  input  logic       green,
  input  logic       yellow,
  input  logic       red,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [6:0] countdown,
  output logic       fault
);

  localparam logic [6:0] C_WALK_LOAD  = 7'(WALK_TIME);
  localparam logic [6:0] C_CLEAR_LOAD = 7'(CLEAR_TIME);

  ped_state_t r_state;
  ped_state_t w_state_nxt;
  logic       r_red_d;
  logic       r_flash;
  logic       w_flash_nxt;
  logic [6:0] w_count_nxt;
  logic       w_walk_nxt;
  logic       w_dont_walk_nxt;
  logic       w_pulse;
  logic       w_red_rise;
  logic       w_conflict;
  logic       w_enter_walk;
  logic       w_count_tick;

  ped_btn_sync u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (ped_btn),
    .pulse (w_pulse)
  );

  assign w_red_rise   = red & ~r_red_d;
  assign w_conflict   = ((r_state == C_ST_WALK) || (r_state == C_ST_CLEAR)) &&
                        (!red || green || yellow);
  assign w_enter_walk = (r_state == C_ST_IDLE) && (w_state_nxt == C_ST_WALK);
  assign w_count_tick = tick && (countdown != 7'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A conflicting vehicle aspect or loss of enable aborts any crossing.
  always_comb begin
    w_state_nxt = r_state;
    if (w_conflict || !enable) begin
      w_state_nxt = C_ST_IDLE;
    end else begin
      case (r_state)
        C_ST_IDLE:  if (req_pending && w_red_rise) w_state_nxt = C_ST_WALK;
        C_ST_WALK:  if (w_count_tick && countdown == 7'd1) w_state_nxt = C_ST_CLEAR;
        C_ST_CLEAR: if (w_count_tick && countdown == 7'd1) w_state_nxt = C_ST_HOLD;
        C_ST_HOLD:  if (!red) w_state_nxt = C_ST_IDLE;
        default:    w_state_nxt = C_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_count_nxt = countdown;
    w_flash_nxt = r_flash;
    if (w_conflict || !enable) begin
      w_count_nxt = 7'd0;
    end else begin
      case (r_state)
        C_ST_IDLE: if (w_enter_walk) w_count_nxt = C_WALK_LOAD;
        C_ST_WALK: begin
          if (w_count_tick) begin
            if (countdown == 7'd1) begin
              w_count_nxt = C_CLEAR_LOAD;
              w_flash_nxt = 1'b1;
            end else begin
              w_count_nxt = countdown - 7'd1;
            end
          end
        end
        C_ST_CLEAR: begin
          if (w_count_tick) begin
            w_flash_nxt = ~r_flash;
            w_count_nxt = countdown - 7'd1;
          end
        end
        default: w_count_nxt = 7'd0;
      endcase
    end
  end

  always_comb begin
    w_walk_nxt      = 1'b0;
    w_dont_walk_nxt = 1'b1;
    case (w_state_nxt)
      C_ST_WALK: begin
        w_walk_nxt      = 1'b1;
        w_dont_walk_nxt = 1'b0;
      end
      C_ST_CLEAR: w_dont_walk_nxt = w_flash_nxt;
      default: begin
        w_walk_nxt      = 1'b0;
        w_dont_walk_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      countdown   <= 7'd0;
      fault       <= 1'b0;
      r_flash     <= 1'b0;
      r_red_d     <= 1'b0;
    end else begin
      walk      <= w_walk_nxt;
      dont_walk <= w_dont_walk_nxt;
      countdown <= w_count_nxt;
      r_flash   <= w_flash_nxt;
      r_red_d   <= red;
      if (w_conflict) fault <= 1'b1;
      // Service clears the request; presses while it is set are absorbed.
      if (!enable || w_enter_walk) begin
        req_pending <= 1'b0;
      end else if (w_pulse) begin
        req_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ped_signal.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ped_signal : randomized and directed checks against a behavioural model
// Revision 1.0
// ------------------------------------------------------------------
module tb_ped_signal;

  localparam int WALK_T  = 7;
  localparam int CLEAR_T = 10;

  typedef enum int {M_IDLE, M_WALK, M_CLEAR, M_HOLD} mphase_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       green = 1'b1;
  logic       yellow = 1'b0;
  logic       red = 1'b0;
  logic       ped_btn = 1'b0;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [6:0] countdown;
  logic       fault;

  int n_total = 0;
  int n_bad = 0;
  int tick_period = 2;
  int tcnt = 0;

  mphase_t m_phase = M_IDLE;
  int      m_left = 0;
  bit      m_flash = 0;
  bit      m_req = 0;
  bit      m_fault = 0;
  bit      m_red_prev = 0;
  bit      m_hist [3] = '{default: 0};

  ped_signal #(.WALK_TIME(WALK_T), .CLEAR_TIME(CLEAR_T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .tick        (tick),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .req_pending (req_pending),
    .countdown   (countdown),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Behavioural model of one clock edge, written from the crossing rules.
  task automatic model_edge();
    bit pulse, rise, conflict, go;
    if (!rst_n) begin
      m_phase = M_IDLE; m_left = 0; m_flash = 0; m_req = 0; m_fault = 0;
      m_red_prev = 0; m_hist = '{default: 0};
      return;
    end
    pulse    = m_hist[1] && !m_hist[2];
    rise     = red && !m_red_prev;
    conflict = (m_phase == M_WALK || m_phase == M_CLEAR) && (!red || green || yellow);
    go = 0;
    if (conflict) m_fault = 1;
    if (conflict || !enable) begin
      m_phase = M_IDLE;
      m_left  = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (m_req && rise) begin m_phase = M_WALK; m_left = WALK_T; go = 1; end
        M_WALK: if (tick && m_left > 0) begin
          m_left--;
          if (m_left == 0) begin m_phase = M_CLEAR; m_left = CLEAR_T; m_flash = 1; end
        end
        M_CLEAR: if (tick && m_left > 0) begin
          m_flash = !m_flash;
          m_left--;
          if (m_left == 0) m_phase = M_HOLD;
        end
        M_HOLD: if (!red) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
    if (!enable || go) m_req = 0;
    else if (pulse) m_req = 1;
    m_red_prev = red;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = ped_btn;
  endtask

  function automatic logic [10:0] exp_vec();
    bit ew, ed;
    ew = (m_phase == M_WALK);
    ed = (m_phase == M_CLEAR) ? m_flash : (m_phase != M_WALK);
    return {ew, ed, m_req, 7'(m_left), m_fault};
  endfunction

  function automatic logic [10:0] act_vec();
    return {walk, dont_walk, req_pending, countdown, fault};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (tick_period > 0) tick = (tcnt % tick_period == 0);
    else tick = ($urandom_range(0, 2) == 0);
    tcnt++;
  endtask

  task automatic set_lights(input logic g, input logic y, input logic r);
    green = g; yellow = y; red = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; set_lights(1, 0, 0);
    step(); step();
    n_total++;
    if (act_vec() !== {1'b0, 1'b1, 1'b0, 7'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset_values act=%h exp=%h", act_vec(), {1'b0, 1'b1, 1'b0, 7'd0, 1'b0});
    end
    n_total++;
    if (act_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_model act=%h exp=%h", act_vec(), exp_vec());
    end
    rst_n = 1'b1; enable = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_basic_walk();
    int wt, ct;
    set_lights(1, 0, 0);
    ped_btn = 1'b1; step(); step(); ped_btn = 1'b0;
    repeat (4) begin
      step(); n_total++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL basic_press act=%h exp=%h", act_vec(), exp_vec()); end
    end
    n_total++;
    if (req_pending !== 1'b1) begin n_bad++; $display("FAIL basic_req act=%b exp=1", req_pending); end
    set_lights(0, 1, 0); step(); step();
    set_lights(0, 0, 1); step();
    n_total++;
    if (walk !== 1'b1 || countdown !== 7'd7 || req_pending !== 1'b0) begin
      n_bad++; $display("FAIL basic_entry walk=%b cd=%0d req=%b exp walk=1 cd=7 req=0", walk, countdown, req_pending);
    end
    wt = 0; ct = 0;
    for (int i = 0; i < 100 && (walk || countdown != 7'd0); i++) begin
      if (walk && tick) wt++;
      if (!walk && countdown != 7'd0) begin
        if (tick) ct++;
        n_total++;
        if (dont_walk !== !countdown[0]) begin
          n_bad++; $display("FAIL basic_flash cd=%0d act=%b exp=%b", countdown, dont_walk, !countdown[0]);
        end
      end
      step(); n_total++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL basic_seq act=%h exp=%h", act_vec(), exp_vec()); end
    end
    n_total++;
    if (wt != WALK_T || ct != CLEAR_T) begin
      n_bad++; $display("FAIL basic_durations walk_ticks=%0d clear_ticks=%0d exp %0d %0d", wt, ct, WALK_T, CLEAR_T);
    end
    n_total++;
    if (dont_walk !== 1'b1 || walk !== 1'b0) begin
      n_bad++; $display("FAIL basic_hold dont_walk=%b walk=%b exp 1 0", dont_walk, walk);
    end
    set_lights(1, 0, 0);
    repeat (3) step();
  endtask

  task automatic test_late_press();
    bit seen;
    set_lights(1, 0, 0); repeat (5) step();
    set_lights(0, 1, 0); ped_btn = 1'b1; step(); step();
    set_lights(0, 0, 1); step(); ped_btn = 1'b0;
    n_total++;
    if (req_pending !== 1'b1 || walk !== 1'b0) begin
      n_bad++; $display("FAIL late_req req=%b walk=%b exp 1 0", req_pending, walk);
    end
    seen = 0;
    repeat (20) begin
      step(); seen |= walk; n_total++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL late_seq act=%h exp=%h", act_vec(), exp_vec()); end
    end
    n_total++;
    if (seen) begin n_bad++; $display("FAIL late_nowalk act=1 exp=0"); end
    set_lights(1, 0, 0); repeat (5) step();
    set_lights(0, 1, 0); repeat (2) step();
    set_lights(0, 0, 1); step();
    n_total++;
    if (walk !== 1'b1) begin n_bad++; $display("FAIL late_next_walk act=%b exp=1", walk); end
    for (int i = 0; i < 100 && (walk || countdown != 7'd0); i++) step();
    set_lights(1, 0, 0); repeat (3) step();
  endtask

  task automatic test_multi_press();
    int walks;
    bit prev;
    set_lights(1, 0, 0);
    repeat (3) begin
      ped_btn = 1'b1; step(); step();
      ped_btn = 1'b0; step(); step(); step();
    end
    set_lights(0, 1, 0); repeat (2) step();
    set_lights(0, 0, 1);
    walks = 0; prev = 0;
    repeat (60) begin
      step(); n_total++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL multi_seq act=%h exp=%h", act_vec(), exp_vec()); end
      if (walk && !prev) begin
        walks++; n_total++;
        if (req_pending !== 1'b0) begin n_bad++; $display("FAIL multi_req_clear act=%b exp=0", req_pending); end
      end
      prev = walk;
    end
    n_total++;
    if (walks != 1) begin n_bad++; $display("FAIL multi_walks act=%0d exp=1", walks); end
    set_lights(1, 0, 0); repeat (3) step();
  endtask

  task automatic test_fault();
    int wt;
    set_lights(1, 0, 0);
    ped_btn = 1'b1; step(); step(); ped_btn = 1'b0;
    repeat (4) step();
    set_lights(0, 1, 0); repeat (2) step();
    set_lights(0, 0, 1); step();
    wt = 0;
    for (int i = 0; i < 50; i++) begin
      if (walk && tick) begin
        if (wt == 2) break;
        wt++;
      end
      step();
    end
    set_lights(1, 0, 0); step();
    n_total++;
    if ({fault, walk, dont_walk, countdown} !== {1'b1, 1'b0, 1'b1, 7'd0}) begin
      n_bad++; $display("FAIL fault_abort fault=%b walk=%b dw=%b cd=%0d exp 1 0 1 0", fault, walk, dont_walk, countdown);
    end
    repeat (10) step();
    n_total++;
    if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky act=%b exp=1", fault); end
    n_total++;
    if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL fault_model act=%h exp=%h", act_vec(), exp_vec()); end
  endtask

  task automatic test_reset_mid_clear();
    bit seen;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_total++;
    if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault_clear act=%b exp=0", fault); end
    set_lights(1, 0, 0);
    ped_btn = 1'b1; step(); step(); ped_btn = 1'b0;
    repeat (4) step();
    set_lights(0, 1, 0); repeat (2) step();
    set_lights(0, 0, 1); step();
    for (int i = 0; i < 100 && !(!walk && countdown == 7'd4); i++) begin
      step(); n_total++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL rstclr_seq act=%h exp=%h", act_vec(), exp_vec()); end
    end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_total++;
    if (act_vec() !== {1'b0, 1'b1, 1'b0, 7'd0, 1'b0}) begin
      n_bad++; $display("FAIL rstclr_values act=%h exp=%h", act_vec(), {1'b0, 1'b1, 1'b0, 7'd0, 1'b0});
    end
    seen = 0;
    repeat (20) step_and_watch(seen);
    set_lights(1, 0, 0); repeat (5) step();
    set_lights(0, 1, 0); repeat (2) step();
    set_lights(0, 0, 1);
    repeat (20) step_and_watch(seen);
    n_total++;
    if (seen) begin n_bad++; $display("FAIL rstclr_no_resume act=1 exp=0"); end
    set_lights(1, 0, 0); repeat (3) step();
  endtask

  task automatic step_and_watch(inout bit seen);
    step();
    seen |= walk;
  endtask

  task automatic test_enable_drop();
    bit seen;
    set_lights(1, 0, 0);
    ped_btn = 1'b1; step(); step(); ped_btn = 1'b0;
    repeat (4) step();
    set_lights(0, 1, 0); repeat (2) step();
    set_lights(0, 0, 1); step();
    ped_btn = 1'b1; step(); step(); ped_btn = 1'b0; step();
    n_total++;
    if (walk !== 1'b1 || req_pending !== 1'b1) begin
      n_bad++; $display("FAIL en_prestate walk=%b req=%b exp 1 1", walk, req_pending);
    end
    enable = 1'b0; step();
    n_total++;
    if ({walk, dont_walk, req_pending, countdown} !== {1'b0, 1'b1, 1'b0, 7'd0}) begin
      n_bad++; $display("FAIL en_drop walk=%b dw=%b req=%b cd=%0d exp 0 1 0 0", walk, dont_walk, req_pending, countdown);
    end
    enable = 1'b1;
    seen = 0;
    repeat (20) step_and_watch(seen);
    set_lights(1, 0, 0); repeat (5) step();
    set_lights(0, 1, 0); repeat (2) step();
    set_lights(0, 0, 1);
    repeat (20) step_and_watch(seen);
    n_total++;
    if (seen) begin n_bad++; $display("FAIL en_no_walk act=1 exp=0"); end
    n_total++;
    if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL en_model act=%h exp=%h", act_vec(), exp_vec()); end
    set_lights(1, 0, 0); repeat (3) step();
  endtask

  task automatic test_random();
    int ph, left, btn_left, dis_left;
    ph = 0; left = 10; btn_left = 0; dis_left = 0;
    tick_period = 0;
    for (int c = 0; c < 4000; c++) begin
      if (left == 0) begin
        ph = (ph + 1) % 3;
        left = (ph == 0) ? $urandom_range(5, 30) : (ph == 1) ? $urandom_range(2, 5) : $urandom_range(10, 80);
      end
      left--;
      set_lights(ph == 0, ph == 1, ph == 2);
      if (ph == 2 && $urandom_range(0, 299) == 0) red = 1'b0;
      if (btn_left > 0) btn_left--;
      else if ($urandom_range(0, 39) == 0) btn_left = $urandom_range(1, 6);
      ped_btn = (btn_left > 0);
      if (dis_left > 0) dis_left--;
      else if ($urandom_range(0, 399) == 0) dis_left = $urandom_range(1, 5);
      enable = (dis_left == 0);
      rst_n = ($urandom_range(0, 1499) != 0);
      step(); n_total++;
      if (act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random_seq cycle=%0d act=%h exp=%h", c, act_vec(), exp_vec());
      end
      n_total++;
      if (walk === 1'b1 && dont_walk === 1'b1) begin
        n_bad++; $display("FAIL random_exclusive walk=1 dont_walk=1 exp not both");
      end
    end
    rst_n = 1'b1; enable = 1'b1; ped_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_walk();
    test_late_press();
    test_multi_press();
    test_fault();
    test_reset_mid_clear();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
